adc_frame_deserializer: RTL and testbench

ADC_FRAME_DESERIALIZER -- requirements
Module: adc_frame_deserializer

---
 rtl/adc_spi_pkg.sv | 20 ++
 rtl/adc_word_shifter.sv | 53 +++++
 rtl/adc_frame_deserializer.sv | 176 +++++++++++++++++
 tb/tb_adc_frame_deserializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared constants and FSM encodings for the ADC SPI path.
// Used by the frame deserializer and by the SPI master.
package adc_spi_pkg;

   // Default frame geometry: one status word followed by NUM_CH channel words.
   localparam int ADC_WORD_BITS   = 32;
   localparam int ADC_DATA_BITS   = 24;
   localparam int ADC_NUM_CH      = 4;

   // Fixed widths of the published results.
   localparam int ADC_STATUS_BITS = 16;
   localparam int ADC_CH_BITS     = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STATUS  = 2'd1,
      ST_CHANNEL = 2'd2
   } adc_state_t;

endpackage

// File: rtl/adc_word_shifter.sv
// adc_word_shifter: MSB-first serial-to-parallel word assembler.
// Ports:
//   i_clk       - serial clock, rising edge
//   i_rst_n     - synchronous active-low reset
//   i_cs_n      - chip select, active low; high clears the partial word
//   i_miso      - serial data
//   o_word      - word completed on this edge (includes the live bit)
//   o_word_done - high on the edge that samples the last bit of a word
//   o_bit_cnt   - bits already collected for the current word
module adc_word_shifter
   import adc_spi_pkg::*;
#(
   parameter int WORD_BITS = ADC_WORD_BITS
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_cs_n,
   input  logic                         i_miso,
   output logic [WORD_BITS-1:0]         o_word,
   output logic                         o_word_done,
   output logic [$clog2(WORD_BITS)-1:0] o_bit_cnt
);

   localparam int CW = $clog2(WORD_BITS);

   logic [WORD_BITS-1:0] r_shift;
   logic [CW-1:0]        r_bit_cnt;
   logic                 w_last;
   logic                 w_unused;

   assign w_last = (r_bit_cnt == CW'(WORD_BITS - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (i_cs_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_shift   <= {r_shift[WORD_BITS-2:0], i_miso};
         r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
      end
   end

   // The completing bit is taken live so the word is usable on its own edge;
   // the oldest stored bit is therefore never needed.
   assign o_word      = {r_shift[WORD_BITS-2:0], i_miso};
   assign o_word_done = !i_cs_n && w_last;
   assign o_bit_cnt   = r_bit_cnt;
   assign w_unused    = r_shift[WORD_BITS-1];

endmodule

// File: rtl/adc_frame_deserializer.sv
// adc_frame_deserializer: assembles status + NUM_CH channel words into a held frame.
// Ports:
//   SPI_SCLK_Temp - serial clock, all logic on rising edge
//   reset_n       - synchronous active-low reset
//   spi_cs_n      - chip select (active low); high aborts any partial frame
//   spi_miso      - ADC serial data, MSB first
//   frame_ack     - consumer acknowledge of the held frame
//   status_word   - upper 16 bits of word 0
//   ch_data       - sign-extended channel results, channel 0 in [31:0]
//   frame_valid   - complete unacknowledged frame held
//   overrun       - sticky, an unacknowledged frame was overwritten
//   frame_count   - completed frames mod 256
//   abort_count   - discarded partial frames, saturating
//   state_dbg     - FSM state encoding
module adc_frame_deserializer
   import adc_spi_pkg::*;
#(
   parameter int WORD_BITS = ADC_WORD_BITS,
   parameter int DATA_BITS = ADC_DATA_BITS,
   parameter int NUM_CH    = ADC_NUM_CH
) (
   input  logic                  SPI_SCLK_Temp,
   input  logic                  reset_n,
   input  logic                  spi_cs_n,
   input  logic                  spi_miso,
   input  logic                  frame_ack,
   output logic [15:0]           status_word,
   output logic [NUM_CH*32-1:0]  ch_data,
   output logic                  frame_valid,
   output logic                  overrun,
   output logic [7:0]            frame_count,
   output logic [7:0]            abort_count,
   output logic [1:0]            state_dbg
);

   localparam int IW = $clog2(NUM_CH + 1);
   localparam int CW = $clog2(WORD_BITS);

   logic [WORD_BITS-1:0]       w_word;
   logic                       w_word_done;
   logic [CW-1:0]              w_bit_cnt;
   logic [DATA_BITS-1:0]       w_data;
   logic                       w_frame_done;
   logic                       w_abort;
   logic                       w_unused;

   adc_state_t                 r_state;
   logic [IW-1:0]              r_word_idx;
   logic [15:0]                r_status_hold;
   logic [DATA_BITS-1:0]       r_hold [NUM_CH];

   logic [15:0]                r_status_word;
   logic [NUM_CH*32-1:0]       r_ch_data;
   logic                       r_frame_valid;
   logic                       r_overrun;
   logic [7:0]                 r_frame_count;
   logic [7:0]                 r_abort_count;

   function automatic logic [31:0] f_sext(input logic [DATA_BITS-1:0] d);
      return {{(32 - DATA_BITS){d[DATA_BITS-1]}}, d};
   endfunction

   adc_word_shifter #(
      .WORD_BITS (WORD_BITS)
   ) u_shifter (
      .i_clk       (SPI_SCLK_Temp),
      .i_rst_n     (reset_n),
      .i_cs_n      (spi_cs_n),
      .i_miso      (spi_miso),
      .o_word      (w_word),
      .o_word_done (w_word_done),
      .o_bit_cnt   (w_bit_cnt)
   );

   // Conversion result sits MSB-aligned; the low pad bits carry nothing.
   assign w_data   = w_word[WORD_BITS-1 -: DATA_BITS];
   assign w_unused = ^w_word[WORD_BITS-DATA_BITS-1:0];

   assign w_frame_done = (r_state == ST_CHANNEL) && w_word_done
                         && (r_word_idx == IW'(NUM_CH));

   // A burst counts as aborted once anything of it has been sampled,
   // including a fresh status word started after a completed frame.
   assign w_abort = spi_cs_n
                    && ((r_state != ST_IDLE) || (w_bit_cnt != '0));

   // Frame sequencing: which word is arriving and where it is parked.
   always_ff @(posedge SPI_SCLK_Temp) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_word_idx    <= '0;
         r_status_hold <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_hold[c] <= '0;
         end
      end else if (spi_cs_n) begin
         r_state    <= ST_IDLE;
         r_word_idx <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE, ST_STATUS: begin
               if (w_word_done) begin
                  r_status_hold <= w_word[WORD_BITS-1 -: 16];
                  r_word_idx    <= IW'(1);
                  r_state       <= ST_CHANNEL;
               end else begin
                  r_state <= ST_STATUS;
               end
            end
            ST_CHANNEL: begin
               if (w_word_done) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     if (r_word_idx == IW'(c + 1)) begin
                        r_hold[c] <= w_data;
                     end
                  end
                  if (r_word_idx == IW'(NUM_CH)) begin
                     r_word_idx <= '0;
                     r_state    <= ST_STATUS;
                  end else begin
                     r_word_idx <= r_word_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_word_idx <= '0;
            end
         endcase
      end
   end

   // Published frame, handshake and statistics.
   always_ff @(posedge SPI_SCLK_Temp) begin
      if (!reset_n) begin
         r_status_word <= '0;
         r_ch_data     <= '0;
         r_frame_valid <= 1'b0;
         r_overrun     <= 1'b0;
         r_frame_count <= '0;
         r_abort_count <= '0;
      end else begin
         if (w_abort && (r_abort_count != 8'hFF)) begin
            r_abort_count <= r_abort_count + 8'd1;
         end
         if (w_frame_done) begin
            r_status_word <= r_status_hold;
            // Last channel is still on the wire; earlier ones are parked.
            for (int c = 0; c < NUM_CH; c++) begin
               if (c == NUM_CH - 1) begin
                  r_ch_data[c*32 +: 32] <= f_sext(w_data);
               end else begin
                  r_ch_data[c*32 +: 32] <= f_sext(r_hold[c]);
               end
            end
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            // An ack on the completing edge consumes the old frame in time.
            if (r_frame_valid && !frame_ack) begin
               r_overrun <= 1'b1;
            end
         end else if (r_frame_valid && frame_ack) begin
            r_frame_valid <= 1'b0;
         end
      end
   end

   assign status_word = r_status_word;
   assign ch_data     = r_ch_data;
   assign frame_valid = r_frame_valid;
   assign overrun     = r_overrun;
   assign frame_count = r_frame_count;
   assign abort_count = r_abort_count;
   assign state_dbg   = r_state;

endmodule

// File: tb/tb_adc_frame_deserializer.sv
// tb_adc_frame_deserializer: table vectors, corner sequences and random
// bursts checked against a frame-level reference model.
module tb_adc_frame_deserializer;

   localparam int NW = 5;
   localparam int FB = 32 * NW;

   logic         clk;
   logic         reset_n;
   logic         spi_cs_n;
   logic         spi_miso;
   logic         frame_ack;
   logic [15:0]  status_word;
   logic [127:0] ch_data;
   logic         frame_valid;
   logic         overrun;
   logic [7:0]   frame_count;
   logic [7:0]   abort_count;
   logic [1:0]   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int n_edge   = 0;

   adc_frame_deserializer dut (
      .SPI_SCLK_Temp (clk),
      .reset_n       (reset_n),
      .spi_cs_n      (spi_cs_n),
      .spi_miso      (spi_miso),
      .frame_ack     (frame_ack),
      .status_word   (status_word),
      .ch_data       (ch_data),
      .frame_valid   (frame_valid),
      .overrun       (overrun),
      .frame_count   (frame_count),
      .abort_count   (abort_count),
      .state_dbg     (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: bits since CS fell, and the bits of the frame in flight.
   bit          mq[$];
   int          m_burst;
   logic [15:0] m_status;
   logic [31:0] m_ch [4];
   logic        m_valid;
   logic        m_ovr;
   logic [7:0]  m_fc;
   logic [7:0]  m_ac;

   function automatic logic [31:0] sx(input logic [31:0] w);
      int v;
      v = int'(w >> 8);
      if (v >= (1 << 23)) v = v - (1 << 24);
      return 32'(v);
   endfunction

   task automatic model_edge(input logic rst, input logic cs,
                             input logic miso, input logic ack);
      logic [31:0] wd [NW];
      bit done;
      done = 0;
      if (!rst) begin
         mq.delete();
         m_burst  = 0;
         m_status = '0;
         for (int c = 0; c < 4; c++) m_ch[c] = '0;
         m_valid  = 0;
         m_ovr    = 0;
         m_fc     = '0;
         m_ac     = '0;
         return;
      end
      if (cs) begin
         if (m_burst > 0 && m_ac != 8'd255) m_ac = m_ac + 8'd1;
         m_burst = 0;
         mq.delete();
      end else begin
         mq.push_back(miso);
         m_burst++;
         if (mq.size() == FB) begin
            for (int k = 0; k < NW; k++) begin
               wd[k] = '0;
               for (int b = 0; b < 32; b++)
                  wd[k] = {wd[k][30:0], logic'(mq[k*32+b])};
            end
            mq.delete();
            done = 1;
         end
      end
      if (done) begin
         if (m_valid && !ack) m_ovr = 1;
         m_valid  = 1;
         m_fc     = m_fc + 8'd1;
         m_status = wd[0][31:16];
         for (int c = 0; c < 4; c++) m_ch[c] = sx(wd[c+1]);
      end else if (m_valid && ack) begin
         m_valid = 0;
      end
   endtask

   function automatic logic [1:0] m_state();
      if (m_burst == 0) return 2'd0;
      if (mq.size() < 32) return 2'd1;
      return 2'd2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      logic [163:0] a, e;
      a = {status_word, ch_data, frame_valid, overrun,
           frame_count, abort_count, state_dbg};
      e = {m_status, m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_valid, m_ovr,
           m_fc, m_ac, m_state()};
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL model@edge%0d: got %h expected %h", n_edge, a, e);
      end
   endtask

   task automatic edge_(input logic rst, input logic cs,
                        input logic miso, input logic ack);
      reset_n   = rst;
      spi_cs_n  = cs;
      spi_miso  = miso;
      frame_ack = ack;
      @(posedge clk);
      n_edge++;
      model_edge(rst, cs, miso, ack);
      #1;
      cmp_model();
   endtask

   task automatic send_bits(input logic [31:0] w [NW], input int nbits,
                            input bit ack_first, input bit ack_last);
      int i;
      i = 0;
      for (int k = 0; k < NW; k++) begin
         for (int b = 31; b >= 0; b--) begin
            if (i < nbits)
               edge_(1'b1, 1'b0, w[k][b],
                     (ack_first && i == 0) || (ack_last && i == FB - 1));
            i++;
         end
      end
   endtask

   task automatic do_reset();
      edge_(1'b0, 1'b1, 1'b0, 1'b0);
      edge_(1'b0, 1'b1, 1'b0, 1'b0);
      edge_(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [31:0] w  [NW];
      logic [15:0] st;
      logic [31:0] ch [4];
   } vec_t;

   vec_t tbl [3];

   initial begin
      logic [31:0] rw [NW];
      int nb;

      tbl[0].w  = '{32'h2230_0000, 32'h7FFF_FF00, 32'h8000_0000,
                    32'h0000_0100, 32'hFFFF_FF00};
      tbl[0].st = 16'h2230;
      tbl[0].ch = '{32'h007F_FFFF, 32'hFF80_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      tbl[1].w  = '{32'hA5A5_1234, 32'h1234_5678, 32'h8765_43FF,
                    32'h0000_0000, 32'h7FFF_FFFF};
      tbl[1].st = 16'hA5A5;
      tbl[1].ch = '{32'h0012_3456, 32'hFF87_6543, 32'h0000_0000, 32'h007F_FFFF};
      tbl[2].w  = '{32'hFFFF_0000, 32'h8000_00AB, 32'h0080_0000,
                    32'hFF7F_FF00, 32'h0000_FF12};
      tbl[2].st = 16'hFFFF;
      tbl[2].ch = '{32'hFF80_0000, 32'h0000_8000, 32'hFFFF_7FFF, 32'h0000_00FF};

      reset_n = 0; spi_cs_n = 1; spi_miso = 0; frame_ack = 0;
      do_reset();
      chk("rst_status", 32'(status_word), 32'h0);
      chk("rst_ch", 32'(|ch_data), 32'h0);
      chk("rst_valid", 32'(frame_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_fcount", 32'(frame_count), 32'h0);
      chk("rst_acount", 32'(abort_count), 32'h0);
      chk("rst_state", 32'(state_dbg), 32'h0);

      for (int i = 0; i < 3; i++) begin
         send_bits(tbl[i].w, FB, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_status", i), 32'(status_word), 32'(tbl[i].st));
         for (int c = 0; c < 4; c++)
            chk($sformatf("tbl%0d_ch%0d", i, c), ch_data[c*32 +: 32], tbl[i].ch[c]);
         chk($sformatf("tbl%0d_valid", i), 32'(frame_valid), 32'h1);
         chk($sformatf("tbl%0d_fcount", i), 32'(frame_count), 32'(i + 1));
         chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'h1);
         edge_(1'b1, 1'b1, 1'b0, 1'b1);
         chk($sformatf("tbl%0d_acked", i), 32'(frame_valid), 32'h0);
      end

      // Three back-to-back frames, ack on the first edge of the next frame.
      do_reset();
      send_bits(tbl[0].w, FB, 1'b0, 1'b0);
      send_bits(tbl[1].w, FB, 1'b1, 1'b0);
      send_bits(tbl[2].w, FB, 1'b1, 1'b0);
      chk("b2b_fcount", 32'(frame_count), 32'd3);
      chk("b2b_overrun", 32'(overrun), 32'h0);
      chk("b2b_valid", 32'(frame_valid), 32'h1);
      chk("b2b_ch3", ch_data[127:96], 32'h0000_00FF);

      // Two frames, no ack: overwrite flagged and sticky across ack.
      do_reset();
      send_bits(tbl[0].w, FB, 1'b0, 1'b0);
      send_bits(tbl[1].w, FB, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'h1);
      chk("ovr_status", 32'(status_word), 32'hA5A5);
      chk("ovr_ch1", ch_data[63:32], 32'hFF87_6543);
      edge_(1'b1, 1'b1, 1'b0, 1'b1);
      chk("ovr_ack_valid", 32'(frame_valid), 32'h0);
      chk("ovr_sticky", 32'(overrun), 32'h1);

      // Abort after 40 bits, then a full frame.
      do_reset();
      send_bits(tbl[1].w, 40, 1'b0, 1'b0);
      edge_(1'b1, 1'b1, 1'b0, 1'b0);
      send_bits(tbl[2].w, FB, 1'b0, 1'b0);
      chk("abort_acount", 32'(abort_count), 32'd1);
      chk("abort_fcount", 32'(frame_count), 32'd1);
      chk("abort_status", 32'(status_word), 32'hFFFF);
      chk("abort_ch2", ch_data[95:64], 32'hFFFF_7FFF);

      // Ack coinciding with completion of the next frame.
      do_reset();
      send_bits(tbl[0].w, FB, 1'b0, 1'b0);
      send_bits(tbl[1].w, FB, 1'b0, 1'b1);
      chk("ackcoin_valid", 32'(frame_valid), 32'h1);
      chk("ackcoin_overrun", 32'(overrun), 32'h0);
      chk("ackcoin_status", 32'(status_word), 32'hA5A5);
      chk("ackcoin_ch0", ch_data[31:0], 32'h0012_3456);

      // Reset at bit 70 with CS still low, then a full frame.
      do_reset();
      send_bits(tbl[0].w, FB, 1'b0, 1'b0);
      send_bits(tbl[1].w, 70, 1'b0, 1'b0);
      edge_(1'b0, 1'b0, 1'b1, 1'b1);
      chk("midrst_status", 32'(status_word), 32'h0);
      chk("midrst_ch", 32'(|ch_data), 32'h0);
      chk("midrst_valid", 32'(frame_valid), 32'h0);
      chk("midrst_fcount", 32'(frame_count), 32'h0);
      chk("midrst_acount", 32'(abort_count), 32'h0);
      edge_(1'b0, 1'b0, 1'b0, 1'b0);
      edge_(1'b1, 1'b1, 1'b0, 1'b0);
      send_bits(tbl[2].w, FB, 1'b0, 1'b0);
      chk("midrst_after_fcount", 32'(frame_count), 32'd1);
      chk("midrst_after_acount", 32'(abort_count), 32'd0);
      chk("midrst_after_ch3", ch_data[127:96], 32'h0000_00FF);

      // Random bursts: whole frames, ragged bursts, random acks and resets.
      do_reset();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 400);
         else nb = FB * $urandom_range(1, 3);
         for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 2999) == 0)
               edge_(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            else
               edge_(1'b1, 1'b0, 1'($urandom),
                     1'($urandom_range(0, 39) == 0));
         end
         for (int i = 0; i < int'($urandom_range(1, 2)); i++)
            edge_(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
